frame_buffer_read_arbiter: RTL and testbench

Shares the single read port of a frame buffer between two requesters: the real-time display fetch (high priority) and an auxiliary reader such as a snapshot or debug export path (low priority). Read latency through the frame buffer is fixed. The block tags each issued read and routes the returned data to its owner. A starvation counter guarantees the auxiliary requester a slot under continuous display traffic. It sits in the read clock domain, between the display pipeline and the frame buffer read address/data port.

---
 rtl/frame_buffer_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_frame_buffer_read_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_read_arbiter.sv
// frame_buffer_read_arbiter
//
// Shares the single read port of a frame buffer between the real-time display
// fetch (high priority) and an auxiliary reader (low priority). Every issued
// read is tagged with its owner. The tag travels alongside the fixed-latency
// memory read, so the returned pixel reaches the requester that asked for it.
// A wait counter forces an aux grant after MAX_WAIT cycles of display
// contention, so the aux reader cannot be starved by the display.
//
// Ports:
//   clk          read-side clock; all logic runs on its rising edge
//   reset        synchronous, active-high
//   disp_req     display read request; disp_addr is stable while ungranted
//   disp_addr    display read address
//   disp_gnt     combinational; the display request is accepted this cycle
//   disp_rvalid  one-cycle pulse; disp_rdata holds returned data
//   disp_rdata   returned display pixel
//   aux_req      aux read request; aux_addr is stable while ungranted
//   aux_addr     aux read address
//   aux_gnt      combinational; the aux request is accepted this cycle
//   aux_rvalid   one-cycle pulse; aux_rdata holds returned data
//   aux_rdata    returned aux pixel
//   mem_en       registered read enable to the frame buffer
//   mem_addr     registered read address to the frame buffer
//   mem_rdata    frame buffer data, valid RD_LATENCY cycles after mem_en
//   aux_starved  registered; high while the wait counter sits at MAX_WAIT

module frame_buffer_read_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              aux_starved
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]            wait_cnt;
    logic [7:0]            wait_cnt_next;
    logic                  issue_tag;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_owner;
    logic                  exit_valid;
    logic                  exit_owner;

    // A full wait counter overrides display priority for one slot.
    always_comb begin
        disp_gnt = 1'b0;
        aux_gnt  = 1'b0;
        if (!reset) begin
            if (aux_req && (wait_cnt == MAX_WAIT_C)) begin
                aux_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end else if (aux_req) begin
                aux_gnt = 1'b1;
            end
        end
    end

    // The wait counter only measures an unbroken stretch of ungranted aux
    // requests. Dropping aux_req restarts the count.
    always_comb begin
        wait_cnt_next = 8'd0;
        if (reset || !aux_req || aux_gnt) begin
            wait_cnt_next = 8'd0;
        end else if (wait_cnt == MAX_WAIT_C) begin
            wait_cnt_next = MAX_WAIT_C;
        end else begin
            wait_cnt_next = wait_cnt + 8'd1;
        end
    end

    // The last pipeline stage lines up with the cycle mem_rdata is valid.
    assign exit_valid = pipe_valid[RD_LATENCY-1];
    assign exit_owner = pipe_owner[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            aux_starved <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            issue_tag   <= 1'b0;
            pipe_valid  <= '0;
            pipe_owner  <= '0;
            disp_rvalid <= 1'b0;
            aux_rvalid  <= 1'b0;
            disp_rdata  <= '0;
            aux_rdata   <= '0;
        end else begin
            wait_cnt    <= wait_cnt_next;
            // aux_starved is registered, yet it still tracks the counter in
            // the same cycle because it is loaded from the counter's next value.
            aux_starved <= (wait_cnt_next == MAX_WAIT_C);

            mem_en <= disp_gnt | aux_gnt;
            if (aux_gnt) begin
                mem_addr  <= aux_addr;
                issue_tag <= 1'b1;
            end else if (disp_gnt) begin
                mem_addr  <= disp_addr;
                issue_tag <= 1'b0;
            end

            pipe_valid[0] <= mem_en;
            pipe_owner[0] <= issue_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end

            disp_rvalid <= exit_valid && !exit_owner;
            aux_rvalid  <= exit_valid && exit_owner;
            if (exit_valid && !exit_owner) begin
                disp_rdata <= mem_rdata;
            end
            if (exit_valid && exit_owner) begin
                aux_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// tb_frame_buffer_read_arbiter
//
// Scoreboard bench for frame_buffer_read_arbiter. Two instances are built:
// dut0 at the default RD_LATENCY=2 and dut1 with RD_LATENCY=1. Each instance
// has a memory model that returns mem_addr[15:0] after the configured latency.
// When the stimulus tasks issue a grant, they push the expected owner, data
// and arrival cycle into that instance's queue. A monitor per instance pops
// one entry for every rvalid it sees.

module tb_frame_buffer_read_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct packed {
        logic        owner;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    logic [15:0] last0_d = '0, last0_a = '0, last1_d = '0, last1_a = '0;

    logic        d0_disp_req = 0, d0_aux_req = 0;
    logic [18:0] d0_disp_addr = '0, d0_aux_addr = '0;
    logic        d0_disp_gnt, d0_aux_gnt, d0_disp_rvalid, d0_aux_rvalid;
    logic [15:0] d0_disp_rdata, d0_aux_rdata, d0_mem_rdata;
    logic        d0_mem_en, d0_aux_starved;
    logic [18:0] d0_mem_addr;

    logic        d1_disp_req = 0, d1_aux_req = 0;
    logic [18:0] d1_disp_addr = '0, d1_aux_addr = '0;
    logic        d1_disp_gnt, d1_aux_gnt, d1_disp_rvalid, d1_aux_rvalid;
    logic [15:0] d1_disp_rdata, d1_aux_rdata, d1_mem_rdata;
    logic        d1_mem_en, d1_aux_starved;
    logic [18:0] d1_mem_addr;

    logic [15:0] ml0 [LAT0];
    logic [15:0] ml1 [LAT1];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    frame_buffer_read_arbiter #(.ADDR_W(19), .DATA_W(16), .RD_LATENCY(LAT0), .MAX_WAIT(8)) dut0 (
        .clk(clk), .reset(reset),
        .disp_req(d0_disp_req), .disp_addr(d0_disp_addr), .disp_gnt(d0_disp_gnt),
        .disp_rvalid(d0_disp_rvalid), .disp_rdata(d0_disp_rdata),
        .aux_req(d0_aux_req), .aux_addr(d0_aux_addr), .aux_gnt(d0_aux_gnt),
        .aux_rvalid(d0_aux_rvalid), .aux_rdata(d0_aux_rdata),
        .mem_en(d0_mem_en), .mem_addr(d0_mem_addr), .mem_rdata(d0_mem_rdata),
        .aux_starved(d0_aux_starved)
    );

    frame_buffer_read_arbiter #(.ADDR_W(19), .DATA_W(16), .RD_LATENCY(LAT1), .MAX_WAIT(8)) dut1 (
        .clk(clk), .reset(reset),
        .disp_req(d1_disp_req), .disp_addr(d1_disp_addr), .disp_gnt(d1_disp_gnt),
        .disp_rvalid(d1_disp_rvalid), .disp_rdata(d1_disp_rdata),
        .aux_req(d1_aux_req), .aux_addr(d1_aux_addr), .aux_gnt(d1_aux_gnt),
        .aux_rvalid(d1_aux_rvalid), .aux_rdata(d1_aux_rdata),
        .mem_en(d1_mem_en), .mem_addr(d1_mem_addr), .mem_rdata(d1_mem_rdata),
        .aux_starved(d1_aux_starved)
    );

    // Fixed-latency frame buffer models: data is the low 16 address bits
    always @(posedge clk) begin
        ml0[0] <= d0_mem_addr[15:0];
        for (int i = 1; i < LAT0; i++) ml0[i] <= ml0[i-1];
        ml1[0] <= d1_mem_addr[15:0];
        for (int i = 1; i < LAT1; i++) ml1[i] <= ml1[i-1];
    end
    assign d0_mem_rdata = ml0[LAT0-1];
    assign d1_mem_rdata = ml1[LAT1-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Drives one cycle of requests into the selected instance, checks the
    // grants at mid-cycle and records the expected return when a tracked
    // grant is expected.
    task automatic applyStimulus(input int dut, input logic dreq, input logic [18:0] daddr,
                                 input logic areq, input logic [18:0] aaddr,
                                 input logic exp_dg, input logic exp_ag, input logic exp_st,
                                 input logic track);
        exp_t e;
        if (dut == 0) begin
            d0_disp_req = dreq; d0_disp_addr = daddr; d0_aux_req = areq; d0_aux_addr = aaddr;
            d1_disp_req = 0; d1_aux_req = 0;
        end else begin
            d1_disp_req = dreq; d1_disp_addr = daddr; d1_aux_req = areq; d1_aux_addr = aaddr;
            d0_disp_req = 0; d0_aux_req = 0;
        end
        @(negedge clk);
        if (dut == 0) begin
            checkOutput($sformatf("d0_disp_gnt@%0d", cyc), {31'd0, d0_disp_gnt}, {31'd0, exp_dg});
            checkOutput($sformatf("d0_aux_gnt@%0d", cyc), {31'd0, d0_aux_gnt}, {31'd0, exp_ag});
            checkOutput($sformatf("d0_aux_starved@%0d", cyc), {31'd0, d0_aux_starved}, {31'd0, exp_st});
        end else begin
            checkOutput($sformatf("d1_disp_gnt@%0d", cyc), {31'd0, d1_disp_gnt}, {31'd0, exp_dg});
            checkOutput($sformatf("d1_aux_gnt@%0d", cyc), {31'd0, d1_aux_gnt}, {31'd0, exp_ag});
        end
        if (track && (exp_dg || exp_ag)) begin
            e.owner = exp_ag;
            e.data  = exp_ag ? aaddr[15:0] : daddr[15:0];
            e.cyc   = cyc + ((dut == 0) ? LAT0 : LAT1) + 2;
            if (dut == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        d0_disp_req = 0; d0_aux_req = 0; d1_disp_req = 0; d1_aux_req = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_d0_mem_en"}, {31'd0, d0_mem_en}, 32'd0);
        checkOutput({tag, "_d0_mem_addr"}, {13'd0, d0_mem_addr}, 32'd0);
        checkOutput({tag, "_d0_disp_rvalid"}, {31'd0, d0_disp_rvalid}, 32'd0);
        checkOutput({tag, "_d0_aux_rvalid"}, {31'd0, d0_aux_rvalid}, 32'd0);
        checkOutput({tag, "_d0_disp_rdata"}, {16'd0, d0_disp_rdata}, 32'd0);
        checkOutput({tag, "_d0_aux_rdata"}, {16'd0, d0_aux_rdata}, 32'd0);
        checkOutput({tag, "_d0_aux_starved"}, {31'd0, d0_aux_starved}, 32'd0);
        checkOutput({tag, "_d1_mem_en"}, {31'd0, d1_mem_en}, 32'd0);
        checkOutput({tag, "_d1_disp_rdata"}, {16'd0, d1_disp_rdata}, 32'd0);
        checkOutput({tag, "_d1_aux_rdata"}, {16'd0, d1_aux_rdata}, 32'd0);
    endtask

    // Monitor for dut0: every rvalid must match the oldest expected return
    always @(negedge clk) begin
        exp_t e;
        if (d0_disp_rvalid || d0_aux_rvalid) begin
            checkOutput("d0_rvalid_onehot", {31'd0, d0_disp_rvalid & d0_aux_rvalid}, 32'd0);
            if (sb0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d0_unexpected_rvalid cycle=%0d actual disp=%0b aux=%0b required none",
                         cyc, d0_disp_rvalid, d0_aux_rvalid);
            end else begin
                e = sb0.pop_front();
                checkOutput("d0_ret_owner", {31'd0, d0_aux_rvalid}, {31'd0, e.owner});
                checkOutput("d0_ret_cycle", cyc, e.cyc);
                if (e.owner) last0_a = e.data; else last0_d = e.data;
                checkOutput("d0_disp_rdata", {16'd0, d0_disp_rdata}, {16'd0, last0_d});
                checkOutput("d0_aux_rdata", {16'd0, d0_aux_rdata}, {16'd0, last0_a});
            end
        end
    end

    // Monitor for dut1
    always @(negedge clk) begin
        exp_t e;
        if (d1_disp_rvalid || d1_aux_rvalid) begin
            checkOutput("d1_rvalid_onehot", {31'd0, d1_disp_rvalid & d1_aux_rvalid}, 32'd0);
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL d1_unexpected_rvalid cycle=%0d actual disp=%0b aux=%0b required none",
                         cyc, d1_disp_rvalid, d1_aux_rvalid);
            end else begin
                e = sb1.pop_front();
                checkOutput("d1_ret_owner", {31'd0, d1_aux_rvalid}, {31'd0, e.owner});
                checkOutput("d1_ret_cycle", cyc, e.cyc);
                if (e.owner) last1_a = e.data; else last1_d = e.data;
                checkOutput("d1_disp_rdata", {16'd0, d1_disp_rdata}, {16'd0, last1_d});
                checkOutput("d1_aux_rdata", {16'd0, d1_aux_rdata}, {16'd0, last1_a});
            end
        end
    end

    initial begin
        // Power-on reset; a request raised during reset must not be granted
        reset = 1'b1;
        idleCycles(1);
        applyStimulus(0, 1, 19'h00055, 1, 19'h00066, 0, 0, 0, 0);
        checkResetValues("por");
        reset = 1'b0;
        idleCycles(2);

        // Single display read, 0x12C00 -> 0x2C00 four cycles later
        $display("[TB] single display read");
        applyStimulus(0, 1, 19'h12C00, 0, 19'h0, 1, 0, 0, 1);
        checkOutput("d0_mem_en_c1", {31'd0, d0_mem_en}, 32'd1);
        checkOutput("d0_mem_addr_c1", {13'd0, d0_mem_addr}, 32'h12C00);
        idleCycles(8);

        // Continuous contention: forced aux grants in cycles 8 and 17
        $display("[TB] contention starvation");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 1, 19'h00100 + 19'(i), 1, (i <= 8) ? 19'h0AA00 : 19'h0AB00,
                          !(i == 8 || i == 17), (i == 8 || i == 17), (i == 8 || i == 17), 1);
        end
        idleCycles(8);

        // Aux alone, back-to-back addresses 0..9
        $display("[TB] aux back-to-back");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 19'h0, 1, 19'(i), 0, 1, 0, 1);
        end
        idleCycles(8);

        // Aux drops in cycle 5, which restarts the wait; forced grant moves to 14
        $display("[TB] aux toggle restarts wait");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 1, 19'h00400 + 19'(i), (i != 5), 19'h0CC00,
                          (i != 14), (i == 14), (i == 14), 1);
        end
        idleCycles(8);

        // Mid-operation reset discards three in-flight reads
        $display("[TB] mid-operation reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 19'h00300 + 19'(i), 0, 19'h0, 1, 0, 0, 0);
        end
        reset = 1'b1;
        applyStimulus(0, 1, 19'h00303, 0, 19'h0, 0, 0, 0, 0);
        reset = 1'b0;
        last0_d = '0; last0_a = '0; last1_d = '0; last1_a = '0;
        checkResetValues("midrst");
        applyStimulus(0, 1, 19'h00777, 0, 19'h0, 1, 0, 0, 1);
        idleCycles(8);

        // RD_LATENCY=1 instance: alternating owners, then a simultaneous pair
        $display("[TB] latency-1 alternating owners");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                applyStimulus(1, 1, 19'h00100 + 19'(i), 0, 19'h0, 1, 0, 0, 1);
            else
                applyStimulus(1, 0, 19'h0, 1, 19'h00200 + 19'(i), 0, 1, 0, 1);
        end
        applyStimulus(1, 1, 19'h00150, 1, 19'h00250, 1, 0, 0, 1);
        applyStimulus(1, 0, 19'h0, 1, 19'h00250, 0, 1, 0, 1);
        idleCycles(8);

        checkOutput("sb0_drained", sb0.size(), 32'd0);
        checkOutput("sb1_drained", sb1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
